// File: rtl/wash_cycle_ctrl.sv
// Wash-cycle sequencer: IDLE -> FILL -> WASH -> DRAIN -> DONE with a BCD countdown and water level.
// Optional buzzer on DONE entry is enabled by defining WASH_BUZZER_EN.
module wash_cycle_ctrl #(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned FILL_S  = 9,
   parameter int unsigned WASH_S  = 70,
   parameter int unsigned DRAIN_S = 20,
   parameter int unsigned LVL_MAX = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic        i_pause,
   input  logic        i_lid_open,
   output logic [2:0]  o_phase,
   output logic [11:0] o_remain_bcd,
   output logic [3:0]  o_level,
   output logic        o_busy,
   output logic        o_done,
`ifdef WASH_BUZZER_EN
   output logic        o_buzz,
`endif
   output logic [7:0]  o_st_light
);

   localparam int unsigned CNT_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int unsigned PC_W    = 10;
   localparam int unsigned TOTAL_S = FILL_S + WASH_S + DRAIN_S;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_HZ - 1);
   localparam logic [3:0]       LVL_TOP   = 4'(LVL_MAX);
   localparam logic [11:0]      TOTAL_BCD = {4'(TOTAL_S / 100), 4'((TOTAL_S / 10) % 10),
                                             4'(TOTAL_S % 10)};

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StFill  = 3'd1,
      StWash  = 3'd2,
      StDrain = 3'd3,
      StDone  = 3'd4
   } phase_e;

   phase_e           r_phase,     w_phase_nxt;
   logic [11:0]      r_remain,    w_remain_nxt;
   logic [3:0]       r_level,     w_level_nxt;
   logic [PC_W-1:0]  r_phase_cnt, w_phase_cnt_nxt;
   logic [CNT_W-1:0] r_tick_cnt,  w_tick_cnt_nxt;
   logic             r_start_q;
`ifdef WASH_BUZZER_EN
   logic [1:0]       r_buzz_cnt,  w_buzz_cnt_nxt;
`endif

   logic w_busy;
   logic w_run;
   logic w_cnt_en;
   logic w_tick;
   logic w_start_go;

   // BCD decrement with borrow, clamped at 000.
   function automatic logic [11:0] bcd_dec(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      if (v[3:0] != 4'd0) begin
         r[3:0] = v[3:0] - 4'd1;
      end else if (v[7:4] != 4'd0) begin
         r[7:4] = v[7:4] - 4'd1;
         r[3:0] = 4'd9;
      end else if (v[11:8] != 4'd0) begin
         r[11:8] = v[11:8] - 4'd1;
         r[7:4]  = 4'd9;
         r[3:0]  = 4'd9;
      end
      return r;
   endfunction

   assign w_busy     = (r_phase == StFill) || (r_phase == StWash) || (r_phase == StDrain);
   assign w_run      = w_busy & ~i_pause & ~i_lid_open;
   assign w_start_go = i_start & ~r_start_q & ~w_busy;

`ifdef WASH_BUZZER_EN
   // The tick counter keeps running in DONE while the buzzer is sounding.
   assign w_cnt_en = w_run | (r_buzz_cnt != 2'd0);
`else
   assign w_cnt_en = w_run;
`endif

   assign w_tick = w_cnt_en && (r_tick_cnt == CNT_LAST);

   always_comb begin
      w_tick_cnt_nxt = r_tick_cnt;
      if (w_start_go) begin
         w_tick_cnt_nxt = '0;
      end else if (w_cnt_en) begin
         w_tick_cnt_nxt = w_tick ? '0 : r_tick_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      w_phase_nxt     = r_phase;
      w_remain_nxt    = r_remain;
      w_level_nxt     = r_level;
      w_phase_cnt_nxt = r_phase_cnt;
`ifdef WASH_BUZZER_EN
      w_buzz_cnt_nxt  = r_buzz_cnt;
`endif
      if (w_start_go) begin
         w_phase_nxt     = StFill;
         w_remain_nxt    = TOTAL_BCD;
         w_phase_cnt_nxt = PC_W'(FILL_S);
`ifdef WASH_BUZZER_EN
         w_buzz_cnt_nxt  = 2'd0;
`endif
      end else if (w_tick) begin
         if (w_busy) begin
            w_remain_nxt    = bcd_dec(r_remain);
            w_phase_cnt_nxt = r_phase_cnt - PC_W'(1);
         end
         case (r_phase)
            StFill: begin
               if (r_level != LVL_TOP) w_level_nxt = r_level + 4'd1;
               if (r_phase_cnt == PC_W'(1)) begin
                  w_phase_nxt     = StWash;
                  w_phase_cnt_nxt = PC_W'(WASH_S);
               end
            end
            StWash: begin
               if (r_phase_cnt == PC_W'(1)) begin
                  w_phase_nxt     = StDrain;
                  w_phase_cnt_nxt = PC_W'(DRAIN_S);
               end
            end
            StDrain: begin
               if (r_level != 4'd0) w_level_nxt = r_level - 4'd1;
               if (r_phase_cnt == PC_W'(1)) begin
                  w_phase_nxt  = StDone;
                  w_remain_nxt = 12'h000;
                  w_level_nxt  = 4'd0;
`ifdef WASH_BUZZER_EN
                  w_buzz_cnt_nxt = 2'd3;
`endif
               end
            end
`ifdef WASH_BUZZER_EN
            StDone: begin
               if (r_buzz_cnt != 2'd0) w_buzz_cnt_nxt = r_buzz_cnt - 2'd1;
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_phase     <= StIdle;
         r_remain    <= 12'h000;
         r_level     <= 4'd0;
         r_phase_cnt <= '0;
         r_tick_cnt  <= '0;
         r_start_q   <= 1'b0;
`ifdef WASH_BUZZER_EN
         r_buzz_cnt  <= 2'd0;
`endif
      end else begin
         r_phase     <= w_phase_nxt;
         r_remain    <= w_remain_nxt;
         r_level     <= w_level_nxt;
         r_phase_cnt <= w_phase_cnt_nxt;
         r_tick_cnt  <= w_tick_cnt_nxt;
         r_start_q   <= i_start;
`ifdef WASH_BUZZER_EN
         r_buzz_cnt  <= w_buzz_cnt_nxt;
`endif
      end
   end

   always_comb begin
      o_st_light = 8'h00;
      case (r_phase)
         StFill:  o_st_light = 8'h0F;
         StWash:  o_st_light = 8'h3F;
         StDrain: o_st_light = 8'h7F;
         StDone:  o_st_light = 8'hFF;
         default: o_st_light = 8'h00;
      endcase
   end

   assign o_phase      = r_phase;
   assign o_remain_bcd = r_remain;
   assign o_level      = r_level;
   assign o_busy       = w_busy;
   assign o_done       = (r_phase == StDone);
`ifdef WASH_BUZZER_EN
   assign o_buzz       = (r_buzz_cnt != 2'd0);
`endif

endmodule
